race_control: RTL and testbench
===============================

# race_control

Race sequencing stage that sits directly upstream of the main game state machine. It turns the player's start button, the per-frame tick and the finish-line detector into registered race events: start countdown, game start, lap count, race time and race finished. The main FSM and the HUD/overlay consume these outputs to switch layers and draw the counters.

## Interface
- FRAMES_PER_SEC, 60: vsync ticks per countdown second.
- COUNTDOWN_SEC, 3: countdown start value, range 1..3.
- LAPS, 3: laps to finish, range 1..3.
- MIN_LAP_FRAMES, 300: minimum frames between counted crossings.
- TIME_W, 16: race/lap time width, in frames.

- pclk  in  1  pixel clock, sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- vsync_tick  in  1  one-cycle pulse per frame.
- start_btn  in  1  debounced, synchronised level.
- finish_line  in  1  level, high while the player overlaps the finish line.
- countdown  out  2  remaining countdown seconds.
- game_start  out  1  one-cycle pulse when the race begins.
- racing  out  1  level, high during the race.
- race_finished  out  1  level, high in FINISHED.
- lap  out  2  completed laps.
- race_time  out  TIME_W  frames since game_start, saturating.
- best_lap  out  TIME_W  shortest completed lap; present only with the macro.

## Operation
- FSM states: IDLE, COUNTDOWN, RACING, FINISHED.
- Rising edges of start_btn and finish_line are detected internally (prev-sample registers). Levels are ignored.
- IDLE, start edge -> COUNTDOWN.
  - countdown = COUNTDOWN_SEC.
  - frame counter = 0.
- COUNTDOWN:
  - Each vsync_tick increments the frame counter.
  - On the tick that brings it to FRAMES_PER_SEC: counter clears and countdown decrements.
  - When the decrement takes countdown 1 -> 0: go to RACING, pulse game_start.
    - race_time = 0, lap = 0, lap timer = 0.
  - A start edge in COUNTDOWN is ignored.
- RACING:
  - Each vsync_tick increments race_time and the lap timer. Both saturate at all-ones.
  - A finish edge with lap timer >= MIN_LAP_FRAMES is a valid crossing: lap increments and the lap timer clears.
  - A finish edge with lap timer < MIN_LAP_FRAMES is discarded.
  - When a valid crossing makes lap == LAPS: go to FINISHED.
- FINISHED:
  - race_time, lap and best_lap freeze.
  - Start edge -> IDLE. countdown, lap and race_time clear there.
- Simultaneous events:
  - vsync_tick and a valid crossing in the same cycle: both take effect.
  - The lap-timer comparison uses its pre-increment value.
  - The lap timer clears rather than increments.
- Reset (asserted any time, including mid-race): all state clears immediately.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE.
  - countdown 0.
  - game_start 0, racing 0, race_finished 0.
  - lap 0, race_time 0.
  - best_lap all-ones.
- Edge latency: an input sampled high in cycle N (low in N-1) acts at the clock ending cycle N. The output changes in cycle N+1.
- countdown shows COUNTDOWN_SEC in the cycle after the start edge.
- game_start is high exactly one cycle, coincident with racing first going high.
- racing and race_finished are never high together.
- Countdown duration: exactly COUNTDOWN_SEC*FRAMES_PER_SEC vsync ticks after the start edge.

## Configuration
- RACE_CONTROL_BEST_LAP_EN defined:
  - On each valid crossing, best_lap = min(best_lap, lap timer).
  - best_lap is reset to all-ones at game_start.
- Not defined:
  - The best_lap port and its register are absent.
  - All other behaviour is identical.

## Structure
- Package race_pkg:
  - state enum race_state_t (IDLE, COUNTDOWN, RACING, FINISHED).
  - LAP_W = 2.
  - Default timing constants.
- Sub-module edge_detect: a registered rising-edge detector with async active-low reset. Instantiated twice, for start_btn and finish_line.

## Test plan
Bench parameters: FRAMES_PER_SEC=4, COUNTDOWN_SEC=3, LAPS=2, MIN_LAP_FRAMES=8.
- Start edge in IDLE, then 12 vsync ticks:
  - countdown runs 3,2,1.
  - On the 12th tick: game_start pulses for 1 cycle, racing=1, countdown=0.
- In RACING, finish edge at lap timer 5 -> lap stays 0. Edge at lap timer 8 -> lap=1 and the lap timer clears.
- Second valid crossing -> lap=2, race_finished=1, racing=0. race_time stays frozen across further ticks.
- finish_line held high 20 frames -> at most one lap counted.
- vsync_tick and a finish edge in the same cycle, lap timer at 8 -> crossing is counted and race_time still increments.
- rst_n low mid-COUNTDOWN -> asynchronously countdown=0 and state is IDLE.
- With RACE_CONTROL_BEST_LAP_EN:
  - Laps of 10 and 9 frames -> best_lap=9.
  - After reset, best_lap = all-ones.

Source files
------------

// File: rtl/race_control_pkg.sv
// Shared types and default timing constants for the race sequencing stage.
package race_pkg;
   typedef enum logic [1:0] {IDLE, COUNTDOWN, RACING, FINISHED} race_state_t;

   localparam int LAP_W              = 2;
   localparam int DEF_FRAMES_PER_SEC = 60;
   localparam int DEF_COUNTDOWN_SEC  = 3;
   localparam int DEF_LAPS           = 3;
   localparam int DEF_MIN_LAP_FRAMES = 300;
   localparam int DEF_TIME_W         = 16;
endpackage

// File: rtl/race_control_if.sv
// Player/frame inputs and race event outputs of race_control.
// best_lap exists only when RACE_CONTROL_BEST_LAP_EN is defined.
interface race_control_if #(parameter int TIME_W = 16);
   import race_pkg::*;

   logic              vsync_tick;
   logic              start_btn;
   logic              finish_line;
   logic [1:0]        countdown;
   logic              game_start;
   logic              racing;
   logic              race_finished;
   logic [LAP_W-1:0]  lap;
   logic [TIME_W-1:0] race_time;
`ifdef RACE_CONTROL_BEST_LAP_EN
   logic [TIME_W-1:0] best_lap;
`endif

   modport master (
      output vsync_tick, start_btn, finish_line,
      input  countdown, game_start, racing, race_finished, lap, race_time
`ifdef RACE_CONTROL_BEST_LAP_EN
      , input best_lap
`endif
   );

   modport slave (
      input  vsync_tick, start_btn, finish_line,
      output countdown, game_start, racing, race_finished, lap, race_time
`ifdef RACE_CONTROL_BEST_LAP_EN
      , output best_lap
`endif
   );
endinterface

// File: rtl/race_control_edge_detect.sv
// Rising-edge detector: one prev-sample register, edge valid in the cycle the input goes high.
module edge_detect (
   input  logic pclk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);
   logic d_q;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) d_q <= 1'b0;
      else        d_q <= d;
   end

   assign rise = d & ~d_q;
endmodule

// File: rtl/race_control.sv
// Race sequencer: start countdown, race timing, lap counting and finish.
// Optional best-lap tracking is enabled by defining RACE_CONTROL_BEST_LAP_EN.
module race_control
   import race_pkg::*;
#(
   parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
   parameter int COUNTDOWN_SEC  = DEF_COUNTDOWN_SEC,
   parameter int LAPS           = DEF_LAPS,
   parameter int MIN_LAP_FRAMES = DEF_MIN_LAP_FRAMES,
   parameter int TIME_W         = DEF_TIME_W
) (
   input  logic          pclk,
   input  logic          rst_n,
   race_control_if.slave bus
);
   localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [TIME_W-1:0] T_MAX = '1;

   logic              start_e, fin_e, valid_x;
   race_state_t       state;
   logic [FC_W-1:0]   frame_cnt;
   logic [1:0]        countdown_q;
   logic              game_start_q, racing_q, finished_q;
   logic [LAP_W-1:0]  lap_q, lap_inc;
   logic [TIME_W-1:0] race_time_q, lap_tmr;
`ifdef RACE_CONTROL_BEST_LAP_EN
   logic [TIME_W-1:0] best_q;
`endif

   edge_detect u_start_ed (.pclk(pclk), .rst_n(rst_n), .d(bus.start_btn),   .rise(start_e));
   edge_detect u_fin_ed   (.pclk(pclk), .rst_n(rst_n), .d(bus.finish_line), .rise(fin_e));

   // Crossing qualification uses the lap timer before this cycle's tick.
   assign valid_x = fin_e && (lap_tmr >= TIME_W'(MIN_LAP_FRAMES));
   assign lap_inc = lap_q + LAP_W'(1);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         frame_cnt    <= '0;
         countdown_q  <= '0;
         game_start_q <= 1'b0;
         racing_q     <= 1'b0;
         finished_q   <= 1'b0;
         lap_q        <= '0;
         race_time_q  <= '0;
         lap_tmr      <= '0;
`ifdef RACE_CONTROL_BEST_LAP_EN
         best_q       <= T_MAX;
`endif
      end else begin
         game_start_q <= 1'b0;
         case (state)
            IDLE: if (start_e) begin
               state       <= COUNTDOWN;
               countdown_q <= 2'(COUNTDOWN_SEC);
               frame_cnt   <= '0;
            end
            COUNTDOWN: if (bus.vsync_tick) begin
               if (frame_cnt == FC_W'(FRAMES_PER_SEC - 1)) begin
                  frame_cnt   <= '0;
                  countdown_q <= countdown_q - 2'd1;
                  if (countdown_q == 2'd1) begin
                     state        <= RACING;
                     game_start_q <= 1'b1;
                     racing_q     <= 1'b1;
                     race_time_q  <= '0;
                     lap_q        <= '0;
                     lap_tmr      <= '0;
`ifdef RACE_CONTROL_BEST_LAP_EN
                     best_q       <= T_MAX;
`endif
                  end
               end else begin
                  frame_cnt <= frame_cnt + FC_W'(1);
               end
            end
            RACING: begin
               if (bus.vsync_tick && race_time_q != T_MAX)
                  race_time_q <= race_time_q + TIME_W'(1);
               if (valid_x) begin
                  lap_q   <= lap_inc;
                  lap_tmr <= '0;
`ifdef RACE_CONTROL_BEST_LAP_EN
                  if (lap_tmr < best_q) best_q <= lap_tmr;
`endif
                  if (lap_inc == LAP_W'(LAPS)) begin
                     state      <= FINISHED;
                     racing_q   <= 1'b0;
                     finished_q <= 1'b1;
                  end
               end else if (bus.vsync_tick && lap_tmr != T_MAX) begin
                  lap_tmr <= lap_tmr + TIME_W'(1);
               end
            end
            FINISHED: if (start_e) begin
               state       <= IDLE;
               finished_q  <= 1'b0;
               countdown_q <= '0;
               lap_q       <= '0;
               race_time_q <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.countdown     = countdown_q;
   assign bus.game_start    = game_start_q;
   assign bus.racing        = racing_q;
   assign bus.race_finished = finished_q;
   assign bus.lap           = lap_q;
   assign bus.race_time     = race_time_q;
`ifdef RACE_CONTROL_BEST_LAP_EN
   assign bus.best_lap      = best_q;
`endif
endmodule

// File: tb/tb_race_control.sv
// Bench for race_control against an event-level race model; best_lap checks
// are included when RACE_CONTROL_BEST_LAP_EN is defined.
module tb_race_control;
   localparam int FPS    = 4;
   localparam int CD     = 3;
   localparam int LAPS   = 2;
   localparam int MINLAP = 8;
   localparam int TW     = 16;
   localparam int TMAX   = (1 << TW) - 1;

   logic pclk = 1'b0;
   logic rst_n = 1'b0;
   always #5 pclk = ~pclk;

   race_control_if #(.TIME_W(TW)) rif ();

   race_control #(
      .FRAMES_PER_SEC(FPS), .COUNTDOWN_SEC(CD), .LAPS(LAPS),
      .MIN_LAP_FRAMES(MINLAP), .TIME_W(TW)
   ) dut (.pclk(pclk), .rst_n(rst_n), .bus(rif));

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Model: phase 0 idle, 1 countdown, 2 racing, 3 finished.
   int m_phase, m_cd_ticks, m_rt, m_lt, m_laps, m_best, m_gs;
   bit m_prev_s, m_prev_f;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_cd();
      return (m_phase == 1) ? CD - m_cd_ticks / FPS : 0;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_cd_ticks = 0; m_rt = 0; m_lt = 0; m_laps = 0;
      m_best = TMAX; m_gs = 0; m_prev_s = 0; m_prev_f = 0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit f);
      bit s_e, f_e, valid;
      s_e = s && !m_prev_s;
      f_e = f && !m_prev_f;
      m_prev_s = s;
      m_prev_f = f;
      m_gs = 0;
      case (m_phase)
         0: if (s_e) begin m_phase = 1; m_cd_ticks = 0; end
         1: if (t) begin
            m_cd_ticks++;
            if (m_cd_ticks == CD * FPS) begin
               m_phase = 2; m_gs = 1; m_rt = 0; m_laps = 0; m_lt = 0; m_best = TMAX;
            end
         end
         2: begin
            valid = f_e && (m_lt >= MINLAP);
            if (t && m_rt < TMAX) m_rt++;
            if (valid) begin
               if (m_lt < m_best) m_best = m_lt;
               m_lt = 0;
               m_laps++;
               if (m_laps == LAPS) m_phase = 3;
            end else if (t && m_lt < TMAX) m_lt++;
         end
         default: if (s_e) begin m_phase = 0; m_rt = 0; m_laps = 0; end
      endcase
   endtask

   task automatic cyc(input bit t, input bit s, input bit f);
      rif.vsync_tick  = t;
      rif.start_btn   = s;
      rif.finish_line = f;
      @(posedge pclk);
      if (!rst_n) model_reset();
      else        model_step(t, s, f);
      #1;
   endtask

   task automatic start_race();
      cyc(0, 1, 0);
      repeat (CD * FPS) cyc(1, 0, 0);
   endtask

   always @(negedge pclk) begin
      if (chk_en) begin
         chk("countdown",     int'(rif.countdown),     exp_cd());
         chk("game_start",    int'(rif.game_start),    m_gs);
         chk("racing",        int'(rif.racing),        int'(m_phase == 2));
         chk("race_finished", int'(rif.race_finished), int'(m_phase == 3));
         chk("lap",           int'(rif.lap),           m_laps);
         chk("race_time",     int'(rif.race_time),     m_rt);
`ifdef RACE_CONTROL_BEST_LAP_EN
         chk("best_lap",      int'(rif.best_lap),      m_best);
`endif
      end
   end

   initial begin
      rif.vsync_tick = 0; rif.start_btn = 0; rif.finish_line = 0;
      model_reset();
      repeat (2) cyc(0, 0, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      cyc(0, 0, 0);
      chk("rst_countdown", int'(rif.countdown), 0);
      chk("rst_racing", int'(rif.racing), 0);
      chk("rst_race_time", int'(rif.race_time), 0);
`ifdef RACE_CONTROL_BEST_LAP_EN
      chk("rst_best_lap", int'(rif.best_lap), TMAX);
`endif

      // Race 1: countdown, short-lap discard, exact-minimum lap, simultaneous tick+crossing.
      cyc(0, 1, 0);
      chk("cd_after_start", int'(rif.countdown), 3);
      repeat (4) cyc(1, 0, 0);
      chk("cd_after_4", int'(rif.countdown), 2);
      repeat (7) cyc(1, 0, 0);
      chk("cd_after_11", int'(rif.countdown), 1);
      chk("no_race_at_11", int'(rif.racing), 0);
      cyc(1, 0, 0);
      chk("gs_at_12", int'(rif.game_start), 1);
      chk("racing_at_12", int'(rif.racing), 1);
      chk("cd_at_12", int'(rif.countdown), 0);
      cyc(0, 0, 0);
      chk("gs_one_cycle", int'(rif.game_start), 0);
      repeat (5) cyc(1, 0, 0);
      cyc(0, 0, 1);
      chk("short_lap_discard", int'(rif.lap), 0);
      cyc(0, 0, 0);
      repeat (3) cyc(1, 0, 0);
      cyc(0, 0, 1);
      chk("lap1_at_8", int'(rif.lap), 1);
      chk("rt_at_lap1", int'(rif.race_time), 8);
      cyc(0, 0, 0);
      repeat (8) cyc(1, 0, 0);
      cyc(1, 0, 1);
      chk("lap2_simul", int'(rif.lap), 2);
      chk("finished", int'(rif.race_finished), 1);
      chk("not_racing", int'(rif.racing), 0);
      chk("rt_simul", int'(rif.race_time), 17);
`ifdef RACE_CONTROL_BEST_LAP_EN
      chk("best_race1", int'(rif.best_lap), 8);
`endif
      cyc(0, 0, 0);
      repeat (3) cyc(1, 0, 0);
      chk("rt_frozen", int'(rif.race_time), 17);
      cyc(0, 1, 0);
      chk("idle_lap_clr", int'(rif.lap), 0);
      chk("idle_rt_clr", int'(rif.race_time), 0);
      chk("idle_fin_clr", int'(rif.race_finished), 0);
      cyc(0, 0, 0);

      // Race 2: finish_line held high across many frames counts once.
      start_race();
      repeat (10) cyc(1, 0, 0);
      cyc(0, 0, 1);
      repeat (20) cyc(1, 0, 1);
      chk("held_one_lap", int'(rif.lap), 1);
      chk("held_racing", int'(rif.racing), 1);
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk("race2_done", int'(rif.race_finished), 1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);

      // Race 3: laps of 10 and 9 frames.
      start_race();
      repeat (10) cyc(1, 0, 0);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      repeat (9) cyc(1, 0, 0);
      cyc(0, 0, 1);
      chk("race3_done", int'(rif.race_finished), 1);
`ifdef RACE_CONTROL_BEST_LAP_EN
      chk("best_race3", int'(rif.best_lap), 9);
`endif
      cyc(0, 1, 0);
      cyc(0, 0, 0);

      // Asynchronous reset in the middle of a countdown.
      cyc(0, 1, 0);
      repeat (5) cyc(1, 0, 0);
      chk("cd_before_rst", int'(rif.countdown), 2);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_cd", int'(rif.countdown), 0);
      chk("async_rst_racing", int'(rif.racing), 0);
`ifdef RACE_CONTROL_BEST_LAP_EN
      chk("async_rst_best", int'(rif.best_lap), TMAX);
`endif
      repeat (2) cyc(0, 0, 0);
      rst_n = 1'b1;
      repeat (CD * FPS) cyc(1, 0, 0);
      chk("idle_after_rst", int'(rif.racing), 0);
      chk("idle_cd_after_rst", int'(rif.countdown), 0);
      cyc(0, 0, 0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
